vegeta_pe_mx: RTL and testbench

- Parametrised successor to the fixed-FP6 processing element.
- One systolic PE holding ALPHA processing rows of BETA sparse weight slots, with element width, sparsity group size and array position set by parameters.
- Adds ping-pong weight buffers with a counted load chain, valid-qualified compute, MX shared-scale (E8M0) combination, and error flags.
- Sits in the systolic array:
  - activations travel left to right;
  - weights and partial sums travel top to bottom.

---
 rtl/vegeta_pe_mx.sv | 171 +++++++++++++++++
 tb/tb_vegeta_pe_mx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vegeta_pe_mx.sv
// Parametrised sparse systolic PE: ping-pong weight buffers loaded through a counted
// pass-through chain, valid-qualified MXINT multiply-accumulate and E8M0 scale combination.
module vegeta_pe_mx #(
    parameter int ALPHA  = 4,
    parameter int BETA   = 4,
    parameter int M      = 4,
    parameter int EW     = 8,
    parameter int META   = 2,
    parameter int AW     = 24,
    parameter int ROWS   = 4,
    parameter int ROW_ID = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     mode,
    input  logic [1:0]                     gemm_mode,
    input  logic                           load_start,
    input  logic                           w_valid_in,
    input  logic [ALPHA*BETA*(EW+META)-1:0] weight_in,
    output logic                           w_valid_out,
    output logic [ALPHA*BETA*(EW+META)-1:0] weight_out,
    input  logic                           swap,
    input  logic                           act_valid_in,
    input  logic [EW*M*BETA-1:0]           act_in,
    input  logic [ALPHA*AW-1:0]            acc_in,
    input  logic [7:0]                     input_scale,
    input  logic [7:0]                     weight_scale,
    output logic                           act_valid_out,
    output logic [EW*M*BETA-1:0]           act_out,
    output logic [ALPHA*AW-1:0]            acc_out,
    output logic [7:0]                     output_acc_scale,
    output logic [2:0]                     err
);

    localparam int SW = EW + META;
    localparam int WW = ALPHA * BETA * SW;
    localparam int NA = M * BETA;
    localparam int XW = AW + $clog2(BETA) + 2;
    localparam int IW = (NA > 1) ? $clog2(NA) : 1;
    localparam int CW = $clog2(ROWS + 1);
    localparam logic signed [XW-1:0] ACC_MAX = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [XW-1:0] ACC_MIN = {{(XW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    // Activation element feeding weight slot j; reserved mode 11 falls through to dense.
    function automatic logic [IW-1:0] act_sel(input logic [1:0] gm, input int j,
                                              input logic [META-1:0] mt);
        case (gm)
            2'b01:   act_sel = IW'((j / 2) * M) + IW'(mt);
            2'b10:   act_sel = IW'(j * M) + IW'(mt);
            default: act_sel = IW'(j);
        endcase
    endfunction

    function automatic logic overflows(input logic signed [XW-1:0] x);
        overflows = (x > ACC_MAX) || (x < ACC_MIN);
    endfunction

    function automatic logic [AW-1:0] saturate(input logic signed [XW-1:0] x);
        if (x > ACC_MAX)      saturate = ACC_MAX[AW-1:0];
        else if (x < ACC_MIN) saturate = ACC_MIN[AW-1:0];
        else                  saturate = x[AW-1:0];
    endfunction

    // E8M0 product of scales: 255 is NaN and propagates; otherwise biased sum clamped to 0..254.
    function automatic logic [7:0] comb_scale(input logic [7:0] a, input logic [7:0] b);
        logic signed [9:0] s;
        s = $signed({2'b00, a}) + $signed({2'b00, b}) - 10'sd127;
        if (a == 8'hFF || b == 8'hFF) comb_scale = 8'hFF;
        else if (s < 10'sd0)          comb_scale = 8'h00;
        else if (s > 10'sd254)        comb_scale = 8'd254;
        else                          comb_scale = s[7:0];
    endfunction

    logic [WW-1:0]       buf0, buf1;
    logic                act_idx;
    logic                shadow_full;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       beat_idx_p0, cnt_nxt_p0;
    logic                load_beat_p0, comp_beat_p0;
    logic [WW-1:0]       wact_p0;
    logic [ALPHA*AW-1:0] acc_p0;
    logic                ovf_p0;

    // Stage p0: combinational load bookkeeping and row sums from the active buffer
    assign load_beat_p0 = (mode == 2'b01) && w_valid_in;
    assign comp_beat_p0 = (mode == 2'b10) && act_valid_in;
    assign beat_idx_p0  = load_start ? '0 : cnt;
    assign cnt_nxt_p0   = (beat_idx_p0 >= CW'(ROWS)) ? CW'(ROWS) : beat_idx_p0 + CW'(1);
    assign wact_p0      = act_idx ? buf1 : buf0;

    always_comb begin : datapath_p0
        logic signed [XW-1:0]   sum;
        logic signed [EW-1:0]   w;
        logic signed [EW-1:0]   a;
        logic signed [2*EW-1:0] p;
        logic [SW-1:0]          slot;
        logic [IW-1:0]          idx;
        acc_p0 = '0;
        ovf_p0 = 1'b0;
        sum    = '0;
        w      = '0;
        a      = '0;
        p      = '0;
        slot   = '0;
        idx    = '0;
        for (int r = 0; r < ALPHA; r++) begin
            sum = XW'($signed(acc_in[r*AW +: AW]));
            for (int j = 0; j < BETA; j++) begin
                slot = wact_p0[(r*BETA + j)*SW +: SW];
                w    = $signed(slot[EW-1:0]);
                idx  = act_sel(gemm_mode, j, slot[SW-1:EW]);
                a    = $signed(act_in[idx*EW +: EW]);
                p    = w * a;
                sum  = sum + XW'(p);
            end
            acc_p0[r*AW +: AW] = saturate(sum);
            if (overflows(sum)) ovf_p0 = 1'b1;
        end
    end

    // Stage p1: registered load chain, buffer control and compute outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0             <= '0;
            buf1             <= '0;
            act_idx          <= 1'b0;
            shadow_full      <= 1'b0;
            cnt              <= '0;
            w_valid_out      <= 1'b0;
            weight_out       <= '0;
            act_valid_out    <= 1'b0;
            act_out          <= '0;
            acc_out          <= '0;
            output_acc_scale <= '0;
            err              <= '0;
        end else begin
            w_valid_out <= load_beat_p0;
            if (load_start) begin
                cnt         <= '0;
                shadow_full <= 1'b0;
            end
            if (swap) begin
                if (shadow_full) begin
                    act_idx     <= ~act_idx;
                    shadow_full <= 1'b0;
                end else begin
                    err[0] <= 1'b1;
                end
            end
            if (load_beat_p0) begin
                weight_out <= weight_in;
                cnt        <= cnt_nxt_p0;
                if (beat_idx_p0 == CW'(ROW_ID)) begin
                    if (act_idx) buf0 <= weight_in;
                    else         buf1 <= weight_in;
                    shadow_full <= 1'b1;
                end
            end

            act_valid_out <= comp_beat_p0;
            if (mode == 2'b10) act_out <= act_in;
            if (comp_beat_p0) begin
                acc_out          <= acc_p0;
                output_acc_scale <= comb_scale(input_scale, weight_scale);
                if (gemm_mode == 2'b11) err[1] <= 1'b1;
                if (ovf_p0)             err[2] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vegeta_pe_mx.sv
// Scoreboard bench for vegeta_pe_mx at ROW_ID=2 of a 4-PE column: directed load,
// swap, dense/sparse compute, scale and saturation vectors.
module tb_vegeta_pe_mx;

    localparam int ALPHA = 4, BETA = 4, M = 4, EW = 8, META = 2, AW = 24;
    localparam int ROWS = 4, ROW_ID = 2;
    localparam int SW  = EW + META;
    localparam int WW  = ALPHA * BETA * SW;
    localparam int AB  = EW * M * BETA;
    localparam int ACW = ALPHA * AW;
    localparam int AMAX = 8388607;
    localparam int AMIN = -8388608;

    typedef struct packed {
        logic [AB-1:0]  act;
        logic [ACW-1:0] acc;
        logic [7:0]     sc;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [1:0]     mode;
    logic [1:0]     gemm_mode;
    logic           load_start;
    logic           w_valid_in;
    logic [WW-1:0]  weight_in;
    logic           w_valid_out;
    logic [WW-1:0]  weight_out;
    logic           swap;
    logic           act_valid_in;
    logic [AB-1:0]  act_in;
    logic [ACW-1:0] acc_in;
    logic [7:0]     input_scale;
    logic [7:0]     weight_scale;
    logic           act_valid_out;
    logic [AB-1:0]  act_out;
    logic [ACW-1:0] acc_out;
    logic [7:0]     output_acc_scale;
    logic [2:0]     err;

    logic [WW-1:0] wq[$];
    exp_t          aq[$];
    int            checks   = 0;
    int            failures = 0;

    vegeta_pe_mx #(
        .ALPHA(ALPHA), .BETA(BETA), .M(M), .EW(EW), .META(META), .AW(AW),
        .ROWS(ROWS), .ROW_ID(ROW_ID)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .gemm_mode(gemm_mode),
        .load_start(load_start), .w_valid_in(w_valid_in), .weight_in(weight_in),
        .w_valid_out(w_valid_out), .weight_out(weight_out), .swap(swap),
        .act_valid_in(act_valid_in), .act_in(act_in), .acc_in(acc_in),
        .input_scale(input_scale), .weight_scale(weight_scale),
        .act_valid_out(act_valid_out), .act_out(act_out), .acc_out(acc_out),
        .output_acc_scale(output_acc_scale), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] actual, input logic [255:0] req);
        checks++;
        if (actual !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, req);
        end
    endtask

    // All weights = wv; row 0 slot j carries metadata m0[2j+1:2j], other rows metadata 0.
    function automatic logic [WW-1:0] mk_w(input int wv, input logic [7:0] m0);
        logic [WW-1:0] v;
        logic [1:0]    mt;
        v = '0;
        for (int s = 0; s < ALPHA*BETA; s++) begin
            mt = (s < BETA) ? m0[s*2 +: 2] : 2'b00;
            v[s*SW +: SW] = {mt, wv[EW-1:0]};
        end
        return v;
    endfunction

    // 0: e0..3 = 1,2,3,4 and e5 = 7; 1: ek = k; 2: e0..3 = 1; 3: e0..3 = -1
    function automatic logic [AB-1:0] mk_act(input int kind);
        logic [AB-1:0] v;
        int            e;
        v = '0;
        for (int k = 0; k < M*BETA; k++) begin
            case (kind)
                0:       e = (k < 4) ? k + 1 : ((k == 5) ? 7 : 0);
                1:       e = k;
                2:       e = (k < 4) ? 1 : 0;
                default: e = (k < 4) ? -1 : 0;
            endcase
            v[k*EW +: EW] = e[EW-1:0];
        end
        return v;
    endfunction

    function automatic logic [ACW-1:0] mk_acc(input int r0, input int rest);
        logic [ACW-1:0] v;
        int             t;
        v = '0;
        for (int r = 0; r < ALPHA; r++) begin
            t = (r == 0) ? r0 : rest;
            v[r*AW +: AW] = t[AW-1:0];
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mode         = 2'b00;
        load_start   = 1'b0;
        w_valid_in   = 1'b0;
        act_valid_in = 1'b0;
        swap         = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        idle_in();
        @(negedge clk);
        chk({tag, "_acc_out"}, acc_out, 0);
        chk({tag, "_act_out"}, act_out, 0);
        chk({tag, "_weight_out"}, weight_out, 0);
        chk({tag, "_valids"}, {w_valid_out, act_valid_out}, 0);
        chk({tag, "_scale"}, output_acc_scale, 0);
        chk({tag, "_err"}, err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load(input int wv, input logic [7:0] m0, input int n, input bit incr);
        for (int i = 0; i < n; i++) begin
            mode       = 2'b01;
            load_start = (i == 0);
            w_valid_in = 1'b1;
            weight_in  = mk_w(incr ? wv + i : wv, m0);
            wq.push_back(weight_in);
            step();
        end
        idle_in();
        step();
    endtask

    task automatic do_swap();
        swap = 1'b1;
        step();
        swap = 1'b0;
    endtask

    task automatic comp(input logic [1:0] gm, input logic [AB-1:0] a, input logic [ACW-1:0] ai,
                        input logic [7:0] is, input logic [7:0] ws, input logic sw,
                        input logic [ACW-1:0] ea, input logic [7:0] es);
        exp_t t;
        mode         = 2'b10;
        gemm_mode    = gm;
        act_valid_in = 1'b1;
        act_in       = a;
        acc_in       = ai;
        input_scale  = is;
        weight_scale = ws;
        swap         = sw;
        t.act = a;
        t.acc = ea;
        t.sc  = es;
        aq.push_back(t);
        step();
        swap = 1'b0;
    endtask

    task automatic chk_err(input string name, input logic [2:0] req);
        @(negedge clk);
        chk(name, err, req);
    endtask

    // Monitor: pops and compares whenever the DUT presents a valid output.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (w_valid_out) begin
                    if (wq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL w_unexpected actual=%0h required=no beat", weight_out);
                    end else begin
                        chk("weight_out", weight_out, wq.pop_front());
                    end
                end
                if (act_valid_out) begin
                    if (aq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL act_unexpected actual=%0h required=no beat", acc_out);
                    end else begin
                        exp_t e;
                        e = aq.pop_front();
                        chk("acc_out", acc_out, e.acc);
                        chk("act_out", act_out, e.act);
                        chk("scale", output_acc_scale, e.sc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        gemm_mode    = 2'b00;
        weight_in    = '0;
        act_in       = '0;
        acc_in       = '0;
        input_scale  = '0;
        weight_scale = '0;
        idle_in();
        step();
        do_reset("por");

        // Reset mid-load discards counter and shadow state
        load(1, 8'h00, 2, 1'b0);
        do_reset("midload");
        do_swap();
        chk_err("err_swap_empty", 3'b001);

        // Counted load: ROW_ID=2 captures the third beat (value 3)
        do_reset("load");
        load(1, 8'h00, 4, 1'b1);
        do_swap();
        comp(2'b00, mk_act(0), mk_acc(0, 0), 8'd127, 8'd127, 1'b0, mk_acc(30, 30), 8'd127);
        idle_in();
        step();
        chk_err("err_after_load", 3'b000);

        // Dense compute with scale combinations; metadata must be ignored
        load(2, 8'hFF, 3, 1'b0);
        do_swap();
        comp(2'b00, mk_act(0), mk_acc(10, 10), 8'd130, 8'd125, 1'b0, mk_acc(30, 30), 8'd128);
        comp(2'b00, mk_act(0), mk_acc(10, 10), 8'd250, 8'd200, 1'b0, mk_acc(30, 30), 8'd254);
        comp(2'b00, mk_act(0), mk_acc(10, 10), 8'd255, 8'd1,   1'b0, mk_acc(30, 30), 8'd255);
        comp(2'b00, mk_act(0), mk_acc(10, 10), 8'd10,  8'd20,  1'b0, mk_acc(30, 30), 8'd0);
        mode         = 2'b10;
        act_valid_in = 1'b0;
        acc_in       = mk_acc(1, 1);
        input_scale  = 8'd200;
        step();
        @(negedge clk);
        chk("hold_valid", act_valid_out, 0);
        chk("hold_acc", acc_out, mk_acc(30, 30));
        chk("hold_scale", output_acc_scale, 0);
        idle_in();
        step();

        // Sparse compute: row 0 metadata {0,3,1,2}, activation k = k, weights 1
        load(1, 8'b10_01_11_00, 3, 1'b0);
        do_swap();
        comp(2'b01, mk_act(1), mk_acc(100, 100), 8'd127, 8'd127, 1'b0, mk_acc(114, 108), 8'd127);
        comp(2'b10, mk_act(1), mk_acc(100, 100), 8'd127, 8'd127, 1'b0, mk_acc(130, 124), 8'd127);
        comp(2'b11, mk_act(1), mk_acc(100, 100), 8'd127, 8'd127, 1'b0, mk_acc(106, 106), 8'd127);
        idle_in();
        step();
        chk_err("err_reserved_gemm", 3'b010);

        // Saturation with a swap in the same cycle as the compute beat
        do_reset("ovf");
        load(1, 8'h00, 3, 1'b0);
        do_swap();
        load(2, 8'h00, 3, 1'b0);
        comp(2'b00, mk_act(2), mk_acc(AMAX, AMAX), 8'd127, 8'd127, 1'b1, mk_acc(AMAX, AMAX), 8'd127);
        comp(2'b00, mk_act(2), mk_acc(0, 0), 8'd127, 8'd127, 1'b0, mk_acc(8, 8), 8'd127);
        comp(2'b00, mk_act(3), mk_acc(AMIN, AMIN), 8'd127, 8'd127, 1'b0, mk_acc(AMIN, AMIN), 8'd127);
        idle_in();
        step();
        chk_err("err_overflow", 3'b100);

        step();
        chk("wq_drained", wq.size(), 0);
        chk("aq_drained", aq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
